// File: rtl/vga_timing_delay_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_delay_if
// Description : VGA timing bus plus mouse position pair. Used once on the
//               input side (slave) and once on the delayed output side
//               (master) of vga_timing_delay.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_delay_if #(
  parameter int HW = 11,
  parameter int VW = 10,
  parameter int PW = 12
);
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic          hblnk;
  logic          vblnk;
  logic          hsync;
  logic          vsync;
  logic [PW-1:0] xpos;
  logic [PW-1:0] ypos;

  // Producer side drives every field
  modport master (
    output hcount, vcount, hblnk, vblnk, hsync, vsync, xpos, ypos
  );

  // Consumer side reads every field
  modport slave (
    input hcount, vcount, hblnk, vblnk, hsync, vsync, xpos, ypos
  );
endinterface
`default_nettype wire

// File: rtl/vga_timing_delay.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_delay
// Description : DEPTH-stage delay line for the VGA timing bus and the mouse
//               position pair. Positions are clamped to XMAX/YMAX before
//               entering the pipe. `primed` marks outputs carrying real
//               post-reset data.
//               Optional build macro VGA_DELAY_FRAME_LATCH_EN: the position
//               is latched on each vblnk rising edge so it stays constant
//               for a whole frame.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_delay #(
  parameter int DEPTH = 2,
  parameter int HW    = 11,
  parameter int VW    = 10,
  parameter int PW    = 12,
  parameter int XMAX  = 1023,
  parameter int YMAX  = 767
) (
  input  wire logic         clk,
  input  wire logic         rst,
  vga_timing_delay_if.slave  in_bus,
  vga_timing_delay_if.master out_bus,
  output logic              primed
);

  // One stage word: {hcount, vcount, hblnk, vblnk, hsync, vsync, xpos, ypos}
  localparam int              SW      = HW + VW + 4 + 2 * PW;
  localparam int              CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0]   XMAX_C  = PW'(XMAX);
  localparam logic [PW-1:0]   YMAX_C  = PW'(YMAX);

  logic [PW-1:0] xc;
  logic [PW-1:0] yc;
  logic [PW-1:0] pos_x_in;
  logic [PW-1:0] pos_y_in;

  logic [SW-1:0] stage_q [DEPTH];
  logic [SW-1:0] stage_d [DEPTH];

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Clamp the live position to the visible range (unsigned compare)
  always_comb begin
    xc = (in_bus.xpos > XMAX_C) ? XMAX_C : in_bus.xpos;
    yc = (in_bus.ypos > YMAX_C) ? YMAX_C : in_bus.ypos;
  end

`ifdef VGA_DELAY_FRAME_LATCH_EN
  logic          vblnk_prev_q;
  logic          vblnk_prev_d;
  logic [PW-1:0] held_x_q;
  logic [PW-1:0] held_x_d;
  logic [PW-1:0] held_y_q;
  logic [PW-1:0] held_y_d;
  logic          vblnk_rise;

  // Capture the clamped position on a vblnk rise; the fresh value bypasses
  // the hold register on that cycle so it lines up with vblnk_out rising.
  always_comb begin
    vblnk_rise   = in_bus.vblnk & ~vblnk_prev_q;
    vblnk_prev_d = in_bus.vblnk;
    held_x_d     = held_x_q;
    held_y_d     = held_y_q;
    if (vblnk_rise) begin
      held_x_d = xc;
      held_y_d = yc;
    end
    pos_x_in = held_x_d;
    pos_y_in = held_y_d;
  end

  // Edge-detect history and frame-held position
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblnk_prev_q <= 1'b0;
      held_x_q     <= '0;
      held_y_q     <= '0;
    end else begin
      vblnk_prev_q <= vblnk_prev_d;
      held_x_q     <= held_x_d;
      held_y_q     <= held_y_d;
    end
  end
`else
  // Live clamped position feeds the pipe every cycle
  always_comb begin
    pos_x_in = xc;
    pos_y_in = yc;
  end
`endif

  // Shift-register next state: stage 0 takes the input word, others shift
  always_comb begin
    stage_d[0] = {in_bus.hcount, in_bus.vcount,
                  in_bus.hblnk, in_bus.vblnk, in_bus.hsync, in_bus.vsync,
                  pos_x_in, pos_y_in};
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Pipeline stages; reset discards all in-flight data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  // Prime counter saturates at DEPTH once the pipe holds only fresh data
  always_comb begin
    count_d = (count_q == DEPTH_C) ? count_q : count_q + 1'b1;
  end

  // Prime counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign primed = (count_q == DEPTH_C);

  assign {out_bus.hcount, out_bus.vcount,
          out_bus.hblnk, out_bus.vblnk, out_bus.hsync, out_bus.vsync,
          out_bus.xpos, out_bus.ypos} = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_delay.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_delay
// Description : Self-checking bench for vga_timing_delay. A reference model
//               records every post-reset input sample (with the position it
//               should carry) and predicts the outputs from the sample taken
//               DEPTH edges earlier. Honours VGA_DELAY_FRAME_LATCH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_delay;

  parameter int DEPTH = 2;
  localparam int HW   = 11;
  localparam int VW   = 10;
  localparam int PW   = 12;
  localparam int XMAX = 1023;
  localparam int YMAX = 767;
  localparam logic [PW-1:0] XMAX_C = PW'(XMAX);
  localparam logic [PW-1:0] YMAX_C = PW'(YMAX);

  typedef struct packed {
    logic [HW-1:0] hc;
    logic [VW-1:0] vc;
    logic          hb;
    logic          vb;
    logic          hs;
    logic          vs;
    logic [PW-1:0] x;
    logic [PW-1:0] y;
  } samp_t;

  logic clk;
  logic rst;
  logic primed;

  vga_timing_delay_if #(.HW(HW), .VW(VW), .PW(PW)) in_if ();
  vga_timing_delay_if #(.HW(HW), .VW(VW), .PW(PW)) out_if ();

  vga_timing_delay #(
    .DEPTH (DEPTH),
    .HW    (HW),
    .VW    (VW),
    .PW    (PW),
    .XMAX  (XMAX),
    .YMAX  (YMAX)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_bus  (in_if.slave),
    .out_bus (out_if.master),
    .primed  (primed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  samp_t         hist[$];
  int            n_edges;
  logic          prev_vb;
  logic [PW-1:0] held_x;
  logic [PW-1:0] held_y;

  int errors = 0;
  int checks = 0;

  function automatic logic [PW-1:0] clampv(logic [PW-1:0] v, logic [PW-1:0] m);
    return (v > m) ? m : v;
  endfunction

  task automatic model_reset();
    hist.delete();
    n_edges = 0;
    prev_vb = 1'b0;
    held_x  = '0;
    held_y  = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d (edge %0d)", tag, obs, exp, n_edges);
    end
  endtask

  // Compare every output against the model's prediction for this cycle
  task automatic check_outputs();
    samp_t e;
    logic  ep;
    if (rst || n_edges < DEPTH) begin
      e  = '0;
      ep = 1'b0;
    end else begin
      e  = hist[n_edges - DEPTH];
      ep = 1'b1;
    end
    chk("hcount_out", 32'(out_if.hcount), 32'(e.hc));
    chk("vcount_out", 32'(out_if.vcount), 32'(e.vc));
    chk("strobes_out", 32'({out_if.hblnk, out_if.vblnk, out_if.hsync, out_if.vsync}),
        32'({e.hb, e.vb, e.hs, e.vs}));
    chk("xpos_out", 32'(out_if.xpos), 32'(e.x));
    chk("ypos_out", 32'(out_if.ypos), 32'(e.y));
    chk("primed", 32'(primed), 32'(ep));
  endtask

  // One rising edge: record the sampled inputs, then check 1 ns later
  task automatic tick();
    samp_t s;
    @(posedge clk);
    if (!rst) begin
      s.hc = in_if.hcount;
      s.vc = in_if.vcount;
      s.hb = in_if.hblnk;
      s.vb = in_if.vblnk;
      s.hs = in_if.hsync;
      s.vs = in_if.vsync;
`ifdef VGA_DELAY_FRAME_LATCH_EN
      if (in_if.vblnk && !prev_vb) begin
        held_x = clampv(in_if.xpos, XMAX_C);
        held_y = clampv(in_if.ypos, YMAX_C);
      end
      prev_vb = in_if.vblnk;
      s.x = held_x;
      s.y = held_y;
`else
      s.x = clampv(in_if.xpos, XMAX_C);
      s.y = clampv(in_if.ypos, YMAX_C);
`endif
      hist.push_back(s);
      n_edges++;
    end
    #1;
    check_outputs();
  endtask

  task automatic drive_rand();
    in_if.hcount = HW'($urandom);
    in_if.vcount = VW'($urandom);
    in_if.hblnk  = 1'($urandom);
    in_if.hsync  = 1'($urandom);
    in_if.vsync  = 1'($urandom);
    if ($urandom_range(0, 7) == 0) in_if.vblnk = ~in_if.vblnk;
    in_if.xpos   = PW'($urandom);
    in_if.ypos   = PW'($urandom);
  endtask

  // Asynchronous reset pulse between edges, called at posedge+1
  task automatic async_reset_pulse(input int hold_edges);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs();
    for (int i = 0; i < hold_edges; i++) tick();
    #4;
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    in_if.hcount = '0;
    in_if.vcount = '0;
    in_if.hblnk  = 1'b0;
    in_if.vblnk  = 1'b0;
    in_if.hsync  = 1'b0;
    in_if.vsync  = 1'b0;
    in_if.xpos   = '0;
    in_if.ypos   = '0;
    model_reset();

    // Reset state
    #2;
    check_outputs();
    tick();
    tick();
    #4;
    rst = 1'b0;

    // hcount ramp from release, other fields random
    for (int i = 0; i < DEPTH + 12; i++) begin
      drive_rand();
      in_if.hcount = HW'(i);
      tick();
    end

    // Clamp boundaries
    in_if.vblnk = 1'b0;
    tick();
    begin
      logic [PW-1:0] xs [6];
      logic [PW-1:0] ys [6];
      xs = '{12'd1500, 12'd1023, 12'd0, 12'd1024, 12'd4095, 12'd500};
      ys = '{12'd800,  12'd767,  12'd0, 12'd768,  12'd4095, 12'd766};
      for (int k = 0; k < 6; k++) begin
        in_if.vblnk = 1'b0;
        in_if.xpos  = xs[k];
        in_if.ypos  = ys[k];
        tick();
        in_if.vblnk = 1'b1;
        for (int j = 0; j < DEPTH + 1; j++) tick();
      end
    end

    // Random streaming
    for (int i = 0; i < 200; i++) begin
      drive_rand();
      tick();
    end

    // Mid-operation asynchronous reset while streaming
    async_reset_pulse(2);
    for (int i = 0; i < DEPTH + 6; i++) begin
      drive_rand();
      tick();
    end

    // vblnk held high across reset release with xpos=50
    in_if.vblnk = 1'b1;
    in_if.xpos  = 12'd50;
    in_if.ypos  = 12'd60;
    async_reset_pulse(1);
    tick();
    in_if.xpos = 12'd300;
    in_if.ypos = 12'd310;
    for (int i = 0; i < DEPTH + 3; i++) tick();

    // Position step 100 -> 200 inside a frame, then a vblnk rise
    in_if.vblnk = 1'b0;
    in_if.xpos  = 12'd100;
    in_if.ypos  = 12'd100;
    tick();
    tick();
    in_if.vblnk = 1'b1;
    tick();
    in_if.vblnk = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) tick();
    in_if.xpos = 12'd200;
    in_if.ypos = 12'd200;
    for (int i = 0; i < DEPTH + 3; i++) tick();
    in_if.vblnk = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) tick();

    // Final random burst
    for (int i = 0; i < 100; i++) begin
      drive_rand();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_timing_delay.md
# vga_timing_delay

Parametrised, depth-configurable delay line for the VGA timing bus and the mouse position pair. It sits between the timing generator/mouse interface and the draw stages, aligning hcount/vcount/blank/sync with pipelined pixel logic. Positions are optionally clamped and frame-latched so sprites never tear mid-frame. A `primed` flag marks when the outputs carry real input data after reset.

## Interface
- `DEPTH`, 2, pipeline stages for all delayed signals; legal range 1..16
- `HW`, 11, hcount width
- `VW`, 10, vcount width
- `PW`, 12, xpos/ypos width
- `XMAX`, 1023, upper clamp for xpos (unsigned, fits in PW)
- `YMAX`, 767, upper clamp for ypos (unsigned, fits in PW)

- `clk` in 1 — single clock, all logic on rising edge
- `rst` in 1 — asynchronous, active-high reset
- `hcount`, `vcount` in HW / VW — timing counters
- `hblnk`, `vblnk`, `hsync`, `vsync` in 1 each — timing strobes
- `xpos`, `ypos` in PW — mouse position, unsigned
- `hcount_out`, `vcount_out` out HW / VW — delayed counters
- `hblnk_out`, `vblnk_out`, `hsync_out`, `vsync_out` out 1 each — delayed strobes
- `xpos_out`, `ypos_out` out PW — clamped, optionally frame-latched, delayed position
- `primed` out 1 — high once DEPTH valid cycles have passed since reset release

## Operation
- Timing bus: DEPTH-stage shift register per signal; `*_out` is the last stage. No logic applied.
- Clamp: `xc = (xpos > XMAX) ? XMAX : xpos`; `yc` likewise with YMAX. Unsigned compare at PW bits. Combinational on the inputs, ahead of stage 1.
- Position path: clamped values enter a DEPTH-stage shift register in parallel with the timing bus, so the position and timing stay cycle-aligned at the outputs.
- Prime counter: width ceil(log2(DEPTH+1)). Counts 0..DEPTH after reset release, then saturates. `primed = (count == DEPTH)`.
- Reset (async, any time): all stages, the counter, the held position, and the edge register clear to 0 immediately. Every output reads 0 while `rst` is high, including `primed`. A mid-frame reset discards in-flight data. After release, the counter restarts from 0.

## Timing
- Latency: exactly DEPTH cycles, input to output, for every signal. An input sampled at edge k appears on `*_out` after edge k+DEPTH-1.
- `primed` rises after the DEPTH-th rising edge following reset deassertion. On that same cycle, outputs first reflect post-reset input.
- While `primed`=0, outputs carry reset zeros (syncs inactive-low). Consumers ignore them.
- DEPTH=1 degenerates to a single register stage. `primed` rises after the first edge.

## Configuration
- `VGA_DELAY_FRAME_LATCH_EN` defined: a held register stores the clamped position. It updates only on a vblnk rising edge, detected as `vblnk & ~vblnk_prev`, where `vblnk_prev` is registered and resets to 0. The held value, not the live input, feeds stage 1. On the edge cycle, the freshly clamped value enters stage 1 directly, not the old held value. So `xpos_out`/`ypos_out` change in exactly the cycle `vblnk_out` rises, and are constant from one vblnk rise to the next.
  - If `vblnk`=1 on the first cycle after reset release, that cycle counts as a rising edge and captures.
  - Position changes outside vblnk rises are ignored.
- Not defined: no held register and no edge detect. The clamped live position feeds stage 1 every cycle.

## Test plan
- DEPTH=2: drive hcount 0,1,2,… from reset release -> `hcount_out`=0 for 2 cycles, then 0,1,2,… lagging by 2. `primed` rises with the first valid output.
- Clamp: xpos=1500, ypos=800 -> `xpos_out`=1023, `ypos_out`=767 after DEPTH cycles. xpos=1023 -> 1023 (boundary). xpos=0 -> 0.
- Mid-operation reset: assert `rst` asynchronously between edges while streaming -> all outputs and `primed` read 0 before the next edge. After release, `primed` returns only after DEPTH edges.
- Macro on: xpos steps 100->200 mid-frame with vblnk low -> `xpos_out` stays 100. At the vblnk rise, `xpos_out` becomes 200 in the same cycle `vblnk_out` rises.
- Macro on: `vblnk` held high across reset release with xpos=50 -> captured at the first post-reset edge. `xpos_out`=50 once `primed`.
- DEPTH=1 and DEPTH=16 builds: one-cycle and sixteen-cycle latency on all signals. `primed` timing matches each.
